serial_divisibility_scheduler: RTL and testbench
================================================

Name: serial_divisibility_scheduler

Overview:
- Shares one serial remainder engine between N_REQ requesters.
- Each requester offers a WIDTH-bit operand with a valid/ready handshake.
- The scheduler grants requesters round-robin, captures the operand and feeds it into the remainder datapath, MSB first, one bit per cycle.
- It returns divisibility by DIVISOR, the final remainder and the requester id on a valid/ready result port.

Parameters:
- N_REQ, 4: number of requesters; minimum 2.
- WIDTH, 8: operand width in bits; minimum 1.
- DIVISOR, 5: modulus; range 2..255.
- Derived: RW = $clog2(DIVISOR) (remainder width); IW = $clog2(N_REQ) (id width).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, N_REQ: per-requester operand valid.
- req_ready, output, N_REQ: per-requester accept; at most one bit high.
- req_data, input, N_REQ*WIDTH: flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts result.
- res_div, output, 1: 1 if the operand mod DIVISOR == 0.
- res_rem, output, RW: operand mod DIVISOR.
- res_id, output, IW: index of the requester that owns the result.
- busy, output, 1: high in SHIFT or DONE.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE, res_valid=0, res_div=0, res_rem=0, res_id=0, busy=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - While rst=1, req_ready=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching last+1, last+2, ... modulo N_REQ.
  - req_ready[g]=1 combinationally, only in IDLE and only when some req_valid is high.
  - On a handshake: capture req_data[g] into the shift register, set rem=0, bit counter=0, res_id=g, last=g, go to SHIFT.
  - With no valid request, stay in IDLE.
- SHIFT:
  - Each cycle, b = current MSB of the shift register.
  - rem <= (2*rem + b) − (DIVISOR if 2*rem+b >= DIVISOR else 0). Compute in RW+1 bits; rem is always < DIVISOR.
  - Shift the register left by one and increment the counter.
  - After exactly WIDTH SHIFT cycles, go to DONE.
- DONE:
  - res_valid=1, res_rem=rem, res_div=(rem==0).
  - res_id, res_rem and res_div are held stable while res_ready=0.
  - On res_valid&&res_ready, go to IDLE; res_valid=0 the next cycle.
- Latency and throughput:
  - Request handshake in cycle t → res_valid first high in cycle t+WIDTH+1.
  - Result handshake in cycle u → earliest next request handshake in cycle u+1.
  - Maximum throughput: one operand per WIDTH+2 cycles.
- Operand capture: the operand is sampled at the handshake; req_data may change afterwards without effect.
- Boundaries:
  - Operand 0 → res_div=1, res_rem=0.
  - All-ones operand is handled normally; no overflow, because intermediates are bounded by 2*DIVISOR-1.
  - The round-robin pointer wraps N_REQ-1 → 0.
  - A requester that drops valid before being granted is simply skipped.
  - req_ready is 0 in SHIFT and DONE regardless of req_valid.
- Reset mid-operation (SHIFT or DONE): the operation is discarded, no result is emitted, and all state returns to reset values, including the pointer.
- The pointer advances only on an accepted request, never on a result handshake.

Test Plan:
1. DIVISOR=5, WIDTH=8. Requester 0 sends 35, res_ready=1 → res_valid 9 cycles after the handshake, res_div=1, res_rem=0, res_id=0.
2. Requester 2 sends 37, then 255, then 0 → (div,rem) = (0,2), (1,0), (1,0); res_id=2 each time.
3. All four req_valid held high with distinct data → grant order 0,1,2,3,0,1; each req_ready pulses once per grant; results carry the matching ids.
4. Hold res_ready=0 for 5 cycles in DONE while other requests are pending → res_* stable, req_ready all 0. Raise res_ready → one cycle later the next requester in round-robin order is granted.
5. Assert rst during the 4th SHIFT cycle → next cycle res_valid=0, busy=0. With requesters 1 and 0 both valid afterwards, requester 0 is granted first.
6. Random operands and random res_ready backpressure for DIVISOR=3, 5 and 7 → res_rem equals operand % DIVISOR for every result; no result is lost or duplicated.

Source files
------------

// File: rtl/serial_divisibility_scheduler.sv
// serial_divisibility_scheduler: round-robin shared serial remainder engine (operand mod DIVISOR)
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_data per-requester operand handshake;
//        res_valid/res_ready result handshake carrying res_div, res_rem, res_id; busy high in SHIFT/DONE.
module serial_divisibility_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DIVISOR = 5,
  localparam int RW = $clog2(DIVISOR),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_div,
  output logic [RW-1:0]          res_rem,
  output logic [IW-1:0]          res_id,
  output logic                   busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] sh_q;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] last_q, gnt_id;
  logic found, take;
  logic [RW:0] acc;
  // search starts just after the last granted requester
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= N_REQ; k++)
      if (!found && req_valid[(int'(last_q) + k) % N_REQ]) begin
        found = 1'b1;
        gnt_id = IW'((int'(last_q) + k) % N_REQ);
      end
  end
  assign take = (state_q == IDLE) && !rst && found;
  always_comb begin
    req_ready = '0;
    req_ready[gnt_id] = take;
  end
  // 2*rem+b stays below 2*DIVISOR, so one conditional subtract keeps rem < DIVISOR
  assign acc = {rem_q, sh_q[WIDTH-1]};
  assign rem_d = acc >= (RW+1)'(DIVISOR) ? RW'(acc - (RW+1)'(DIVISOR)) : RW'(acc);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      last_q <= IW'(N_REQ - 1);
      res_valid <= 1'b0;
      res_div <= 1'b0;
      res_rem <= '0;
      res_id <= '0;
      busy <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          sh_q <= req_data[int'(gnt_id)*WIDTH +: WIDTH];
          rem_q <= '0;
          cnt_q <= '0;
          res_id <= gnt_id;
          last_q <= gnt_id;
          busy <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          rem_q <= rem_d;
          sh_q <= sh_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            res_valid <= 1'b1;
            res_rem <= rem_d;
            res_div <= rem_d == '0;
          end
        end
        DONE: if (res_ready) begin
          state_q <= IDLE;
          res_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// tb_serial_divisibility_scheduler: randomized self-checking bench with a plain-arithmetic reference model
module tb_serial_divisibility_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic res_ready;
  logic [3:0] rr5, rr3, rr7;
  logic v5, v3, v7, d5, d3, d7, b5, b3, b7;
  logic [2:0] m5, m7;
  logic [1:0] m3, i5, i3, i7;
  int errors = 0;
  int checks = 0;
  int last;

  always #5 clk = ~clk;

  serial_divisibility_scheduler #(.N_REQ(4), .WIDTH(8), .DIVISOR(5)) dut5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr5), .req_data(req_data),
    .res_valid(v5), .res_ready(res_ready), .res_div(d5), .res_rem(m5), .res_id(i5), .busy(b5));
  serial_divisibility_scheduler #(.N_REQ(4), .WIDTH(8), .DIVISOR(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr3), .req_data(req_data),
    .res_valid(v3), .res_ready(res_ready), .res_div(d3), .res_rem(m3), .res_id(i3), .busy(b3));
  serial_divisibility_scheduler #(.N_REQ(4), .WIDTH(8), .DIVISOR(7)) dut7 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr7), .req_data(req_data),
    .res_valid(v7), .res_ready(res_ready), .res_div(d7), .res_rem(m7), .res_id(i7), .busy(b7));

  function automatic int rr_pick(input logic [3:0] v, input int l);
    for (int k = 1; k <= 4; k++)
      if (v[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = 3;
  endtask

  task automatic wait_ready(output int g, output int n);
    #1;
    n = 0;
    while (rr5 == 4'b0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    g = -1;
    for (int i = 0; i < 4; i++) if (rr5[i]) g = i;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!v5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!v5) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = $urandom;
    res_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rr5 !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", rr5); end
    @(negedge clk);
    checks++; if ({v5, b5, d5} !== 3'b000) begin errors++; $display("FAIL reset_flags: got valid/busy/div=%b expected 000", {v5, b5, d5}); end
    checks++; if ({m5, i5} !== 5'b0) begin errors++; $display("FAIL reset_rem_id: got rem=%0d id=%0d expected 0 0", m5, i5); end
    rst = 1'b0;
    last = 3;
    #1;
    checks++; if (rr5 !== 4'b0001) begin errors++; $display("FAIL reset_priority: got %b expected 0001", rr5); end
    req_valid = '0;
  endtask

  task automatic test_basic;
    int g, n;
    req_valid = 4'b0001;
    req_data = 32'd35;
    res_ready = 1'b1;
    wait_ready(g, n);
    checks++; if (g !== 0) begin errors++; $display("FAIL basic_grant: got %0d expected 0", g); end
    last = 0;
    @(negedge clk);
    req_valid = '0;
    req_data = $urandom;
    #1;
    checks++; if (b5 !== 1'b1 || rr5 !== 4'b0) begin errors++; $display("FAIL basic_shift: got busy=%b ready=%b expected 1 0000", b5, rr5); end
    wait_res(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 9", n + 1); end
    checks++; if ({d5, m5, i5} !== {1'b1, 3'd0, 2'd0}) begin errors++; $display("FAIL basic_result: got div=%b rem=%0d id=%0d expected 1 0 0", d5, m5, i5); end
    @(negedge clk);
    checks++; if (v5 !== 1'b0 || b5 !== 1'b0) begin errors++; $display("FAIL basic_consume: got valid=%b busy=%b expected 0 0", v5, b5); end
  endtask

  task automatic test_multi;
    int ops[3] = '{37, 255, 0};
    int g, n;
    foreach (ops[j]) begin
      req_valid = 4'b0100;
      req_data = 32'(ops[j]) << 16;
      wait_ready(g, n);
      checks++; if (g !== 2) begin errors++; $display("FAIL multi_grant: got %0d expected 2", g); end
      last = 2;
      @(negedge clk);
      req_valid = '0;
      req_data = $urandom;
      wait_res(n);
      checks++; if (int'(m5) !== ops[j] % 5 || d5 !== (ops[j] % 5 == 0) || i5 !== 2'd2)
        begin errors++; $display("FAIL multi_result: op=%0d got div=%b rem=%0d id=%0d expected %0d %0d 2", ops[j], d5, m5, i5, ops[j] % 5 == 0, ops[j] % 5); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin;
    int dat[4];
    int g, n, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dat[i] = $urandom_range(0, 255);
      req_data[i*8 +: 8] = 8'(dat[i]);
    end
    req_valid = 4'hF;
    res_ready = 1'b1;
    repeat (6) begin
      wait_ready(g, n);
      e = rr_pick(4'hF, last);
      checks++; if (g !== e || $countones(rr5) != 1) begin errors++; $display("FAIL rr_grant: got %0d (%b) expected %0d", g, rr5, e); end
      last = e;
      @(negedge clk);
      #1;
      checks++; if (rr5 !== 4'b0) begin errors++; $display("FAIL rr_ready_pulse: got %b expected 0000", rr5); end
      wait_res(n);
      checks++; if (int'(i5) !== e || int'(m5) !== dat[e] % 5) begin errors++; $display("FAIL rr_result: got id=%0d rem=%0d expected %0d %0d", i5, m5, e, dat[e] % 5); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int g, n, e;
    logic [5:0] snap;
    res_ready = 1'b0;
    wait_ready(g, n);
    e = rr_pick(req_valid, last);
    checks++; if (g !== e) begin errors++; $display("FAIL bp_grant: got %0d expected %0d", g, e); end
    last = e;
    @(negedge clk);
    wait_res(n);
    snap = {d5, m5, i5};
    repeat (5) begin
      @(negedge clk);
      #1;
      checks++; if (v5 !== 1'b1 || {d5, m5, i5} !== snap || rr5 !== 4'b0)
        begin errors++; $display("FAIL bp_hold: got valid=%b res=%h ready=%b expected 1 %h 0000", v5, {d5, m5, i5}, rr5, snap); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    e = rr_pick(req_valid, last);
    checks++; if (v5 !== 1'b0 || rr5 !== 4'(1 << e)) begin errors++; $display("FAIL bp_next: got valid=%b ready=%b expected 0 %b", v5, rr5, 4'(1 << e)); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    int g, n;
    bit ghost = 0;
    req_valid = 4'b0001;
    req_data = $urandom;
    wait_ready(g, n);
    checks++; if (g !== 0) begin errors++; $display("FAIL mid_grant: got %0d expected 0", g); end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    #1;
    checks++; if ({v5, b5} !== 2'b00 || rr5 !== 4'b0) begin errors++; $display("FAIL mid_reset: got valid=%b busy=%b ready=%b expected 0 0 0000", v5, b5, rr5); end
    rst = 1'b0;
    last = 3;
    #1;
    checks++; if (rr5 !== 4'b0001) begin errors++; $display("FAIL mid_pointer: got %b expected 0001", rr5); end
    req_valid = '0;
    repeat (12) begin
      @(negedge clk);
      if (v5) ghost = 1;
    end
    checks++; if (ghost) begin errors++; $display("FAIL mid_ghost: got a result expected none"); end
  endtask

  task automatic test_random;
    int q_id[$], q_op[$];
    int pushed = 0, popped = 0, cyc = 0, eg, op;
    bit idle = 1;
    logic [3:0] er;
    while (popped < 40 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      req_valid = pushed < 40 ? 4'($urandom) : 4'b0;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: req_data[i*8 +: 8] = 8'd0;
          1: req_data[i*8 +: 8] = 8'd255;
          default: req_data[i*8 +: 8] = 8'($urandom);
        endcase
      end
      res_ready = $urandom_range(0, 2) != 0;
      #1;
      eg = idle ? rr_pick(req_valid, last) : -1;
      er = eg < 0 ? 4'b0 : 4'(1 << eg);
      checks++; if (rr5 !== er) begin errors++; $display("FAIL rand_ready: got %b expected %b", rr5, er); end
      if (v5) begin
        if (q_id.size() == 0) begin
          checks++; errors++; $display("FAIL rand_dup: got unexpected result id=%0d expected none", i5);
        end else begin
          op = q_op[0];
          checks++; if (int'(i5) !== q_id[0] || int'(m5) !== op % 5 || d5 !== (op % 5 == 0))
            begin errors++; $display("FAIL rand_mod5: op=%0d got id=%0d rem=%0d div=%b expected %0d %0d %0d", op, i5, m5, d5, q_id[0], op % 5, op % 5 == 0); end
          checks++; if (int'(m3) !== op % 3 || d3 !== (op % 3 == 0) || int'(i3) !== q_id[0])
            begin errors++; $display("FAIL rand_mod3: op=%0d got rem=%0d div=%b expected %0d %0d", op, m3, d3, op % 3, op % 3 == 0); end
          checks++; if (int'(m7) !== op % 7 || d7 !== (op % 7 == 0) || int'(i7) !== q_id[0])
            begin errors++; $display("FAIL rand_mod7: op=%0d got rem=%0d div=%b expected %0d %0d", op, m7, d7, op % 7, op % 7 == 0); end
          if (res_ready) begin
            void'(q_id.pop_front());
            void'(q_op.pop_front());
            popped++;
            idle = 1;
          end
        end
      end else if (eg >= 0) begin
        q_id.push_back(eg);
        q_op.push_back(int'(req_data[eg*8 +: 8]));
        last = eg;
        idle = 0;
        pushed++;
      end
    end
    checks++; if (popped !== 40 || q_id.size() != 0) begin errors++; $display("FAIL rand_count: got %0d results (%0d pending) expected 40 (0)", popped, q_id.size()); end
    req_valid = '0;
    res_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
